// File: rtl/de_i2c_pkg.sv
// Shared definitions for the I2C register-initialisation sequencer: FSM state
// encodings, table-word field positions and the delay-entry marker.
package de_i2c_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StIdle = 3'd0;
  localparam state_t StLoad = 3'd1;
  localparam state_t StWait = 3'd2;
  localparam state_t StGap  = 3'd3;
  localparam state_t StNext = 3'd4;
  localparam state_t StDly  = 3'd5;
  localparam state_t StDone = 3'd6;
  localparam state_t StFail = 3'd7;

  localparam int unsigned DEV_MSB  = 23;
  localparam int unsigned SUB_MSB  = 15;
  localparam int unsigned DATA_MSB = 7;

  localparam logic [7:0] DELAY_DEV = 8'hFF;

  function automatic logic [7:0] entry_dev(input logic [23:0] entry);
    return entry[DEV_MSB -: 8];
  endfunction

  // Delay entries carry their tick count in the {sub, data} fields.
  function automatic logic [15:0] entry_delay(input logic [23:0] entry);
    return {entry[SUB_MSB -: 8], entry[DATA_MSB -: 8]};
  endfunction

endpackage

// File: rtl/de_tick_gen.sv
// Free-running divider producing a one-cycle clock-enable pulse every DIV cycles.
module de_tick_gen #(
  parameter int unsigned DIV = 4
) (
  input  logic iCLK,
  input  logic iRST,
  output logic oTICK
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    oTICK = (cnt_q == LAST);
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/de_i2c_init_seq.sv
// I2C register-initialisation sequencer: walks an external table, one write per entry,
// with retry, timeout and sticky status. Optional delay entries via DE_I2C_INIT_DELAY_EN.
module de_i2c_init_seq
  import de_i2c_pkg::*;
#(
  parameter int unsigned CLK_FREQ      = 50000000,
  parameter int unsigned I2C_FREQ      = 20000,
  parameter int unsigned N_ENTRIES     = 50,
  parameter int unsigned IDX_W         = 6,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned TIMEOUT_TICKS = 255,
  parameter int unsigned AUTO_START    = 1
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iSTART,
  output logic [IDX_W-1:0] oIDX,
  input  logic [23:0]      iENTRY,
  output logic             oTICK,
  output logic [23:0]      oI2C_DATA,
  output logic             oGO,
  input  logic             iEND,
  input  logic             iACK,
  output logic             oBUSY,
  output logic             oDONE,
  output logic             oERR,
  output logic [IDX_W-1:0] oERR_IDX
);

  localparam int unsigned      DIV       = CLK_FREQ / (2 * I2C_FREQ);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_ENTRIES - 1);
  localparam logic [7:0]       TOUT_LAST = 8'(TIMEOUT_TICKS - 1);

  logic tick;

  de_tick_gen #(
    .DIV(DIV)
  ) u_tick_gen (
    .iCLK (iCLK),
    .iRST (iRST),
    .oTICK(tick)
  );

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] err_idx_q, err_idx_d;
  logic [23:0]      data_q, data_d;
  logic             go_q, go_d;
  logic [7:0]       tout_q, tout_d;
  logic [7:0]       retry_q, retry_d;
  logic             is_delay;
  logic             start, advance, failed;

`ifdef DE_I2C_INIT_DELAY_EN
  logic [15:0] dly_q, dly_d;
  assign is_delay = (entry_dev(iENTRY) == DELAY_DEV);
`else
  assign is_delay = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    err_idx_d = err_idx_q;
    data_d    = data_q;
    go_d      = go_q;
    tout_d    = tout_q;
    retry_d   = retry_q;
    start     = 1'b0;
    advance   = 1'b0;
    failed    = 1'b0;
`ifdef DE_I2C_INIT_DELAY_EN
    dly_d     = dly_q;
`endif

    if (tick) begin
      case (state_q)
        StIdle: start = (AUTO_START != 0) || iSTART;
        // Holding off while iEND is still high keeps GO from overlapping a stale end.
        StLoad: begin
          if (!iEND) begin
            if (is_delay) begin
`ifdef DE_I2C_INIT_DELAY_EN
              dly_d = entry_delay(iENTRY);
`endif
              state_d = StDly;
            end else begin
              data_d  = iENTRY;
              go_d    = 1'b1;
              tout_d  = '0;
              state_d = StWait;
            end
          end
        end
        StWait: begin
          if (iEND && !iACK) begin
            go_d    = 1'b0;
            state_d = StNext;
          end else if (iEND || (tout_q == TOUT_LAST)) begin
            failed = 1'b1;
          end else begin
            tout_d = tout_q + 8'd1;
          end
        end
        StGap:  if (!iEND) state_d = StLoad;
        StNext: advance = !iEND;
        StDly: begin
`ifdef DE_I2C_INIT_DELAY_EN
          if (dly_q != '0) dly_d = dly_q - 16'd1;
          else             advance = 1'b1;
`else
          advance = 1'b1;
`endif
        end
        StDone, StFail: start = iSTART;
        default: state_d = StIdle;
      endcase
    end

    if (failed) begin
      go_d = 1'b0;
      if (32'(retry_q) < MAX_RETRY) begin
        retry_d = retry_q + 8'd1;
        state_d = StGap;
      end else begin
        err_idx_d = idx_q;
        state_d   = StFail;
      end
    end

    if (advance) begin
      if (idx_q == LAST_IDX) begin
        state_d = StDone;
      end else begin
        idx_d   = idx_q + IDX_W'(1);
        retry_d = '0;
        state_d = StLoad;
      end
    end

    if (start) begin
      idx_d   = '0;
      retry_d = '0;
      state_d = StLoad;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      err_idx_q <= '0;
      data_q    <= '0;
      go_q      <= 1'b0;
      tout_q    <= '0;
      retry_q   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      err_idx_q <= err_idx_d;
      data_q    <= data_d;
      go_q      <= go_d;
      tout_q    <= tout_d;
      retry_q   <= retry_d;
    end
  end

`ifdef DE_I2C_INIT_DELAY_EN
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) dly_q <= '0;
    else      dly_q <= dly_d;
  end
`endif

  always_comb begin
    oTICK     = tick;
    oIDX      = idx_q;
    oI2C_DATA = data_q;
    oGO       = go_q;
    oERR_IDX  = err_idx_q;
    oDONE     = (state_q == StDone);
    oERR      = (state_q == StFail);
    oBUSY     = (state_q == StLoad) || (state_q == StWait) || (state_q == StGap) ||
                (state_q == StNext) || (state_q == StDly);
  end

endmodule

// File: tb/tb_de_i2c_init_seq.sv
// Directed bench for de_i2c_init_seq with a behavioural byte-level I2C controller.
module tb_de_i2c_init_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  idx;
  logic [23:0] entry;
  logic        tick;
  logic [23:0] i2c_data;
  logic        go;
  logic        iend;
  logic        iack;
  logic        busy, done, err;
  logic [1:0]  err_idx;

  logic [23:0] tbl [4];
  int          nack_left [4];
  logic        mute = 1'b0;
  int          gcnt;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign entry = tbl[idx];

  de_i2c_init_seq #(
    .CLK_FREQ     (160000),
    .I2C_FREQ     (20000),
    .N_ENTRIES    (4),
    .IDX_W        (2),
    .MAX_RETRY    (3),
    .TIMEOUT_TICKS(10),
    .AUTO_START   (1)
  ) dut (
    .iCLK     (clk),
    .iRST     (rst),
    .iSTART   (start),
    .oIDX     (idx),
    .iENTRY   (entry),
    .oTICK    (tick),
    .oI2C_DATA(i2c_data),
    .oGO      (go),
    .iEND     (iend),
    .iACK     (iack),
    .oBUSY    (busy),
    .oDONE    (done),
    .oERR     (err),
    .oERR_IDX (err_idx)
  );

  // Controller: raise iEND on the 4th tick of GO, drop it one tick after GO falls.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      iend <= 1'b0;
      iack <= 1'b0;
      gcnt <= 0;
    end else if (tick) begin
      if (go && !iend) begin
        if (!mute) begin
          if (gcnt == 3) begin
            iend <= 1'b1;
            gcnt <= 0;
            if (nack_left[idx] > 0) begin
              iack <= 1'b1;
              nack_left[idx] = nack_left[idx] - 1;
            end else begin
              iack <= 1'b0;
            end
          end else begin
            gcnt <= gcnt + 1;
          end
        end
      end else if (!go && iend) begin
        iend <= 1'b0;
        iack <= 1'b0;
      end
    end
  end

  // GO monitor: log data and tick stamp of every rising GO, plus the last falling stamp.
  int          tick_cnt = 0;
  logic        go_prev = 1'b0;
  logic [23:0] log_data [$];
  int          log_tick [$];
  int          fall_tick = 0;

  always @(negedge clk) begin
    if (go && !go_prev) begin
      log_data.push_back(i2c_data);
      log_tick.push_back(tick_cnt);
    end
    if (!go && go_prev) fall_tick = tick_cnt;
    go_prev = go;
    if (tick) tick_cnt++;
  end

  task automatic set_table();
    tbl[0] = 24'h123456;
    tbl[1] = 24'h123578;
    tbl[2] = 24'h34019A;
    tbl[3] = 24'h3402BC;
    for (int i = 0; i < 4; i++) nack_left[i] = 0;
    mute = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    log_data.delete();
    log_tick.delete();
    rst = 1'b0;
  endtask

  task automatic wait_end(input string name);
    int n;
    n = 0;
    while (!(done || err) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    n_chk++;
    if (!(done || err)) begin
      n_bad++;
      $display("FAIL %s_finish: no DONE/ERR after %0d cycles, required within 3000", name, n);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++; if (idx !== 2'd0)       begin n_bad++; $display("FAIL reset_idx: got %0d want 0", idx); end
    n_chk++; if (go !== 1'b0)        begin n_bad++; $display("FAIL reset_go: got %b want 0", go); end
    n_chk++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_chk++; if (done !== 1'b0)      begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_chk++; if (err !== 1'b0)       begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
    n_chk++; if (err_idx !== 2'd0)   begin n_bad++; $display("FAIL reset_err_idx: got %0d want 0", err_idx); end
    n_chk++; if (i2c_data !== 24'h0) begin n_bad++; $display("FAIL reset_data: got %h want 0", i2c_data); end
  endtask

  task automatic test_happy();
    logic [23:0] exp [$];
    set_table();
    exp = '{24'h123456, 24'h123578, 24'h34019A, 24'h3402BC};
    do_reset();
    wait_end("happy");
    n_chk++; if (log_data.size() != exp.size())
      begin n_bad++; $display("FAIL happy_go_count: got %0d want %0d", log_data.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      logic [23:0] got;
      got = (i < log_data.size()) ? log_data[i] : 24'hxxxxxx;
      n_chk++; if (got !== exp[i]) begin n_bad++; $display("FAIL happy_data%0d: got %h want %h", i, got, exp[i]); end
    end
    n_chk++; if (done !== 1'b1) begin n_bad++; $display("FAIL happy_done: got %b want 1", done); end
    n_chk++; if (err !== 1'b0)  begin n_bad++; $display("FAIL happy_err: got %b want 0", err); end
    n_chk++; if (busy !== 1'b0) begin n_bad++; $display("FAIL happy_busy: got %b want 0", busy); end
    n_chk++; if (idx !== 2'd3)  begin n_bad++; $display("FAIL happy_idx: got %0d want 3", idx); end
  endtask

  task automatic test_retry();
    logic [23:0] exp [$];
    set_table();
    nack_left[2] = 2;
    exp = '{24'h123456, 24'h123578, 24'h34019A, 24'h34019A, 24'h34019A, 24'h3402BC};
    do_reset();
    wait_end("retry");
    n_chk++; if (log_data.size() != exp.size())
      begin n_bad++; $display("FAIL retry_go_count: got %0d want %0d", log_data.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      logic [23:0] got;
      got = (i < log_data.size()) ? log_data[i] : 24'hxxxxxx;
      n_chk++; if (got !== exp[i]) begin n_bad++; $display("FAIL retry_data%0d: got %h want %h", i, got, exp[i]); end
    end
    n_chk++; if (done !== 1'b1) begin n_bad++; $display("FAIL retry_done: got %b want 1", done); end
    n_chk++; if (err !== 1'b0)  begin n_bad++; $display("FAIL retry_err: got %b want 0", err); end
  endtask

  task automatic test_nack_fail();
    logic [23:0] exp [$];
    set_table();
    nack_left[1] = 100;
    exp = '{24'h123456, 24'h123578, 24'h123578, 24'h123578, 24'h123578};
    do_reset();
    wait_end("nack");
    repeat (40) @(negedge clk);
    n_chk++; if (log_data.size() != exp.size())
      begin n_bad++; $display("FAIL nack_go_count: got %0d want %0d", log_data.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      logic [23:0] got;
      got = (i < log_data.size()) ? log_data[i] : 24'hxxxxxx;
      n_chk++; if (got !== exp[i]) begin n_bad++; $display("FAIL nack_data%0d: got %h want %h", i, got, exp[i]); end
    end
    n_chk++; if (err !== 1'b1)     begin n_bad++; $display("FAIL nack_err: got %b want 1", err); end
    n_chk++; if (err_idx !== 2'd1) begin n_bad++; $display("FAIL nack_err_idx: got %0d want 1", err_idx); end
    n_chk++; if (done !== 1'b0)    begin n_bad++; $display("FAIL nack_done: got %b want 0", done); end
    n_chk++; if (busy !== 1'b0)    begin n_bad++; $display("FAIL nack_busy: got %b want 0", busy); end
    n_chk++; if (go !== 1'b0)      begin n_bad++; $display("FAIL nack_go: got %b want 0", go); end
  endtask

  task automatic test_timeout();
    set_table();
    mute = 1'b1;
    do_reset();
    wait_end("timeout");
    n_chk++; if (log_data.size() != 4)
      begin n_bad++; $display("FAIL timeout_go_count: got %0d want 4", log_data.size()); end
    n_chk++; if (log_data.size() > 0 && log_data[0] !== 24'h123456)
      begin n_bad++; $display("FAIL timeout_data: got %h want 123456", log_data[0]); end
    n_chk++; if (log_tick.size() > 0 && (fall_tick - log_tick[log_tick.size()-1]) != 10)
      begin n_bad++; $display("FAIL timeout_go_width: got %0d ticks want 10",
                              fall_tick - log_tick[log_tick.size()-1]); end
    n_chk++; if (err !== 1'b1)     begin n_bad++; $display("FAIL timeout_err: got %b want 1", err); end
    n_chk++; if (err_idx !== 2'd0) begin n_bad++; $display("FAIL timeout_err_idx: got %0d want 0", err_idx); end
    mute = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n;
    set_table();
    do_reset();
    n = 0;
    while (!(idx == 2'd2 && go) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    n_chk++; if (!(idx == 2'd2 && go))
      begin n_bad++; $display("FAIL midrst_reach: idx=%0d go=%b, required idx 2 with GO", idx, go); end
    rst = 1'b1;
    #1;
    n_chk++; if (go !== 1'b0)   begin n_bad++; $display("FAIL midrst_go_async: got %b want 0", go); end
    n_chk++; if (idx !== 2'd0)  begin n_bad++; $display("FAIL midrst_idx: got %0d want 0", idx); end
    repeat (2) @(negedge clk);
    log_data.delete();
    log_tick.delete();
    rst = 1'b0;
    wait_end("midrst");
    n_chk++; if (log_data.size() != 4 || log_data[0] !== 24'h123456)
      begin n_bad++; $display("FAIL midrst_rerun: got %0d GOs want 4 starting at entry 0", log_data.size()); end
    n_chk++; if (done !== 1'b1) begin n_bad++; $display("FAIL midrst_done: got %b want 1", done); end
  endtask

  task automatic test_start();
    int n;
    set_table();
    do_reset();
    n = 0;
    while (!busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    start = 1'b1;
    repeat (12) @(negedge clk);
    start = 1'b0;
    wait_end("start_busy");
    n_chk++; if (log_data.size() != 4)
      begin n_bad++; $display("FAIL start_busy_count: got %0d want 4", log_data.size()); end
    n_chk++; if (done !== 1'b1) begin n_bad++; $display("FAIL start_busy_done: got %b want 1", done); end
    repeat (20) @(negedge clk);
    n_chk++; if (busy !== 1'b0 || done !== 1'b1)
      begin n_bad++; $display("FAIL start_not_queued: busy=%b done=%b want busy 0 done 1", busy, done); end
    log_data.delete();
    log_tick.delete();
    start = 1'b1;
    repeat (12) @(negedge clk);
    start = 1'b0;
    n_chk++; if (busy !== 1'b1 || done !== 1'b0)
      begin n_bad++; $display("FAIL rerun_busy: busy=%b done=%b want busy 1 done 0", busy, done); end
    wait_end("rerun");
    n_chk++; if (log_data.size() != 4 || log_data[0] !== 24'h123456 || log_data[3] !== 24'h3402BC)
      begin n_bad++; $display("FAIL rerun_count: got %0d GOs want 4 covering entries 0..3", log_data.size()); end
    n_chk++; if (done !== 1'b1) begin n_bad++; $display("FAIL rerun_done: got %b want 1", done); end
  endtask

  task automatic test_delay();
    logic [23:0] exp [$];
    set_table();
    tbl[2] = 24'hFF0005;
`ifdef DE_I2C_INIT_DELAY_EN
    exp = '{24'h123456, 24'h123578, 24'h3402BC};
`else
    exp = '{24'h123456, 24'h123578, 24'hFF0005, 24'h3402BC};
`endif
    do_reset();
    wait_end("delay");
    n_chk++; if (log_data.size() != exp.size())
      begin n_bad++; $display("FAIL delay_go_count: got %0d want %0d", log_data.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      logic [23:0] got;
      got = (i < log_data.size()) ? log_data[i] : 24'hxxxxxx;
      n_chk++; if (got !== exp[i]) begin n_bad++; $display("FAIL delay_data%0d: got %h want %h", i, got, exp[i]); end
    end
`ifdef DE_I2C_INIT_DELAY_EN
    // Normal entry-to-entry spacing is 8 ticks; the 5-tick delay entry must add to it.
    n_chk++; if (log_tick.size() < 3 || (log_tick[2] - log_tick[1]) < 13)
      begin n_bad++; $display("FAIL delay_gap: got %0d ticks want >= 13",
                              (log_tick.size() < 3) ? -1 : log_tick[2] - log_tick[1]); end
`endif
    n_chk++; if (done !== 1'b1) begin n_bad++; $display("FAIL delay_done: got %b want 1", done); end
  endtask

  initial begin
    set_table();
    test_reset();
    test_happy();
    test_retry();
    test_nack_fail();
    test_timeout();
    test_reset_mid();
    test_start();
    test_delay();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
